kbd_monkey_ctrl: RTL and testbench
==================================

KBD_MONKEY_CTRL -- requirements
Module: kbd_monkey_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: clocks without a PS/2 falling edge before a partial frame is aborted.
REQ-002 SHALL have parameter KEY_LEFT, default 8'h6B: scancode mapped to digit 4.
REQ-003 SHALL have parameter KEY_RIGHT, default 8'h74: scancode mapped to digit 6.
REQ-004 SHALL have parameter KEY_JUMP, default 8'h29 (space): scancode mapped to jump.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic on posedge clk.
REQ-006 SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port PS2_CLK, input, 1 bit: raw keyboard clock, asynchronous to clk.
REQ-008 SHALL have port PS2_DAT, input, 1 bit: raw keyboard data, asynchronous to clk.
REQ-009 SHALL have port digit, output, 4 bits: active direction digit (4, 6 or 0).
REQ-010 SHALL have port digitIsPressed, output, 1 bit: high while any direction key is held.
REQ-011 SHALL have port jumpIsPressed, output, 1 bit: high while the jump key is held.
REQ-012 SHALL have port frameError, output, 1 bit: one-clock pulse on any discarded frame.

Function
REQ-013 SHALL pass PS2_CLK and PS2_DAT through 2-FF synchronizers; a falling edge is synced clock previous=1, current=0.
REQ-014 SHALL sample PS2_DAT only on detected falling edges; frame = start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-015 SHALL implement FSM IDLE -> DATA -> PARITY -> STOP -> IDLE with a 3-bit bit counter in DATA.
REQ-016 IDLE: edge with data 0 -> DATA; edge with data 1 -> stay IDLE, pulse frameError.
REQ-017 DATA: shift in one bit per edge; after the 8th bit -> PARITY.
REQ-018 PARITY: store the parity bit -> STOP.
REQ-019 STOP: stop=1 and (data XOR parity) odd -> internal byteValid for one clock after the edge; otherwise pulse frameError and discard; always -> IDLE.
REQ-020 SHALL count clocks since the last falling edge, saturating; counter clears on every edge.
REQ-021 When not in IDLE and the counter reaches TIMEOUT_CYCLES: -> IDLE, clear bit counter, pulse frameError once.
REQ-022 Byte 8'hE0 SHALL set the ext flag; byte 8'hF0 SHALL set the rel flag; neither alters key state.
REQ-023 Any other byte SHALL be a key code, applied as press (rel=0) or release (rel=1); ext and rel then clear.
REQ-024 Key matching SHALL ignore ext, so arrow keys (E0 6B / E0 74) act as keypad 4 / 6.
REQ-025 Unmapped key codes SHALL change no key state but still clear ext and rel.
REQ-026 Press KEY_LEFT: leftHeld=1, lastDir=LEFT; press KEY_RIGHT: rightHeld=1, lastDir=RIGHT; release clears only that key's held flag.
REQ-027 Repeated make codes (typematic) SHALL be idempotent apart from refreshing lastDir.
REQ-028 Press or release of KEY_JUMP SHALL set or clear jumpHeld.
REQ-029 digitIsPressed = leftHeld OR rightHeld; jumpIsPressed = jumpHeld.
REQ-030 digit: both held -> 4 if lastDir=LEFT, else 6; only left -> 4; only right -> 6; none -> 0.
REQ-031 Outputs SHALL be registered and update on the clock after byteValid; end-to-end latency is 2 clocks after the synchronized stop-bit edge.
REQ-032 byteValid and a timeout in the same clock cannot coincide (STOP exits to IDLE); if a timeout and an edge coincide, the edge wins and the counter clears.

Reset
REQ-033 On resetN=0, asynchronously: FSM=IDLE, bit counter=0, shift register=0, timeout counter=0, ext=rel=0, leftHeld=rightHeld=jumpHeld=0, lastDir=LEFT, digit=0, digitIsPressed=0, jumpIsPressed=0, frameError=0.
REQ-034 Reset mid-frame SHALL discard the partial byte; the first full frame after release is decoded normally.

Verification
REQ-035 Frame 6B -> digit=4, digitIsPressed=1 two clocks after the stop edge; then F0,6B -> digit=0, digitIsPressed=0.
REQ-036 Send 6B, then 74, then F0,74 -> digit 4, then 6, then 4; digitIsPressed stays 1 throughout.
REQ-037 Send E0,74 then E0,F0,74 -> digit=6, then digit=0; jumpIsPressed stays 0.
REQ-038 Send 29 with bad parity -> one frameError pulse, jumpIsPressed stays 0; a correct 29 then gives jumpIsPressed=1.
REQ-039 Send 4 bits, then idle TIMEOUT_CYCLES clocks -> one frameError pulse, FSM=IDLE; a following 6B gives digit=4.
REQ-040 Hold 6B and 29, then assert resetN=0 mid-frame -> all outputs 0 immediately; after release, F0,29 leaves all outputs 0.

Source files
------------

// File: rtl/kbd_monkey_ctrl.sv
// kbd_monkey_ctrl
// Decodes a PS/2 keyboard stream into game controls: left/right arrows
// (or keypad 4/6) drive a direction digit, space drives jump.
//
// State table (frame receiver)
//   IDLE   | waiting for a start bit (data 0 on a falling PS2_CLK edge)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, then releasing the byte
//
// Ports
//   clk            in   system clock
//   resetN         in   asynchronous active-low reset
//   PS2_CLK        in   raw keyboard clock (asynchronous)
//   PS2_DAT        in   raw keyboard data (asynchronous)
//   digit          out  4 = left, 6 = right, 0 = no direction held
//   digitIsPressed out  any direction key held
//   jumpIsPressed  out  jump key held
//   frameError     out  one-clock pulse per discarded frame
module kbd_monkey_ctrl #(
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  KEY_LEFT       = 8'h6B,
  parameter logic [7:0]  KEY_RIGHT      = 8'h74,
  parameter logic [7:0]  KEY_JUMP       = 8'h29
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [3:0] digit,
  output logic       digitIsPressed,
  output logic       jumpIsPressed,
  output logic       frameError
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          byte_valid, bv_n;
  logic          err_n;

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  logic ext, ext_n, rel, rel_n;
  logic left_held, left_n, right_held, right_n, jump_held, jump_n;
  logic last_left, last_left_n;
  logic [3:0] digit_n;

  // Synchronizers idle high so reset release never looks like an edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= PS2_DAT;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      bitcnt     <= 3'd0;
      shreg      <= 8'd0;
      par        <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frameError <= 1'b0;
    end else begin
      state      <= state_n;
      bitcnt     <= bitcnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      to_cnt     <= to_cnt_n;
      byte_valid <= bv_n;
      frameError <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    bv_n     = 1'b0;
    err_n    = 1'b0;
    to_cnt_n = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TW'(1);
    if (fall) begin
      // An edge always wins over a coincident timeout.
      to_cnt_n = '0;
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n  = DATA;
            bitcnt_n = 3'd0;
          end else begin
            err_n = 1'b1;
          end
        end
        DATA: begin
          shreg_n  = {dat_s2, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          if (dat_s2 && (^{shreg, par})) bv_n  = 1'b1;
          else                           err_n = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && to_cnt >= TO_MAX) begin
      state_n  = IDLE;
      bitcnt_n = 3'd0;
      err_n    = 1'b1;
    end
  end

  // Key tracking. shreg is stable while byte_valid is high because only
  // DATA-state edges shift it.
  always_comb begin
    ext_n       = ext;
    rel_n       = rel;
    left_n      = left_held;
    right_n     = right_held;
    jump_n      = jump_held;
    last_left_n = last_left;
    if (byte_valid) begin
      if (shreg == 8'hE0) begin
        ext_n = 1'b1;
      end else if (shreg == 8'hF0) begin
        rel_n = 1'b1;
      end else begin
        // ext is deliberately ignored so arrows alias keypad 4/6.
        if (shreg == KEY_LEFT) begin
          left_n = ~rel;
          if (!rel) last_left_n = 1'b1;
        end
        if (shreg == KEY_RIGHT) begin
          right_n = ~rel;
          if (!rel) last_left_n = 1'b0;
        end
        if (shreg == KEY_JUMP) jump_n = ~rel;
        ext_n = 1'b0;
        rel_n = 1'b0;
      end
    end
    if (left_n && right_n) digit_n = last_left_n ? 4'd4 : 4'd6;
    else if (left_n)       digit_n = 4'd4;
    else if (right_n)      digit_n = 4'd6;
    else                   digit_n = 4'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ext            <= 1'b0;
      rel            <= 1'b0;
      left_held      <= 1'b0;
      right_held     <= 1'b0;
      jump_held      <= 1'b0;
      last_left      <= 1'b1;
      digit          <= 4'd0;
      digitIsPressed <= 1'b0;
      jumpIsPressed  <= 1'b0;
    end else begin
      ext            <= ext_n;
      rel            <= rel_n;
      left_held      <= left_n;
      right_held     <= right_n;
      jump_held      <= jump_n;
      last_left      <= last_left_n;
      digit          <= digit_n;
      digitIsPressed <= left_n | right_n;
      jumpIsPressed  <= jump_n;
    end
  end

endmodule

// File: tb/tb_kbd_monkey_ctrl.sv
// tb_kbd_monkey_ctrl
// Directed bench for kbd_monkey_ctrl: bit-bangs PS/2 frames and compares
// the decoded outputs against hand-computed values.
module tb_kbd_monkey_ctrl;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       resetN;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [3:0] digit;
  logic       digitIsPressed;
  logic       jumpIsPressed;
  logic       frameError;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int fe_base;

  kbd_monkey_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .PS2_CLK        (PS2_CLK),
    .PS2_DAT        (PS2_DAT),
    .digit          (digit),
    .digitIsPressed (digitIsPressed),
    .jumpIsPressed  (jumpIsPressed),
    .frameError     (frameError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frameError === 1'b1) fe_cnt++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    wait_clk(5);
    PS2_CLK = 1'b0;
    wait_clk(10);
    PS2_CLK = 1'b1;
    wait_clk(5);
  endtask

  // start, data LSB first, parity (optionally inverted)
  task automatic send_head(input logic [7:0] d, input logic bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_head(d, 1'b0);
    ps2_bit(1'b1);
  endtask

  task automatic do_reset();
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    resetN  = 1'b0;
    wait_clk(3);
    resetN  = 1'b1;
    wait_clk(3);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit); end
    checks++; if (digitIsPressed !== 1'b0) begin errors++; $display("FAIL reset_dip: got %b expected 0", digitIsPressed); end
    checks++; if (jumpIsPressed !== 1'b0) begin errors++; $display("FAIL reset_jip: got %b expected 0", jumpIsPressed); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", frameError); end
  endtask

  task automatic test_left_latency();
    do_reset();
    send_head(8'h6B, 1'b0);
    PS2_DAT = 1'b1;
    wait_clk(5);
    PS2_CLK = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL latency_early: got %0d expected 0", digit); end
    @(posedge clk);
    #1;
    checks++; if (digit !== 4'd4) begin errors++; $display("FAIL latency_digit: got %0d expected 4", digit); end
    checks++; if (digitIsPressed !== 1'b1) begin errors++; $display("FAIL latency_dip: got %b expected 1", digitIsPressed); end
    wait_clk(8);
    PS2_CLK = 1'b1;
    wait_clk(5);
    send_byte(8'hF0);
    send_byte(8'h6B);
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL left_release_digit: got %0d expected 0", digit); end
    checks++; if (digitIsPressed !== 1'b0) begin errors++; $display("FAIL left_release_dip: got %b expected 0", digitIsPressed); end
  endtask

  task automatic test_left_right();
    do_reset();
    send_byte(8'h6B);
    checks++; if (digit !== 4'd4) begin errors++; $display("FAIL lr_left: got %0d expected 4", digit); end
    send_byte(8'h74);
    checks++; if (digit !== 4'd6) begin errors++; $display("FAIL lr_both: got %0d expected 6", digit); end
    checks++; if (digitIsPressed !== 1'b1) begin errors++; $display("FAIL lr_both_dip: got %b expected 1", digitIsPressed); end
    send_byte(8'hF0);
    send_byte(8'h74);
    checks++; if (digit !== 4'd4) begin errors++; $display("FAIL lr_rel_right: got %0d expected 4", digit); end
    checks++; if (digitIsPressed !== 1'b1) begin errors++; $display("FAIL lr_rel_right_dip: got %b expected 1", digitIsPressed); end
  endtask

  task automatic test_typematic();
    do_reset();
    send_byte(8'h74);
    send_byte(8'h6B);
    checks++; if (digit !== 4'd4) begin errors++; $display("FAIL typ_last_left: got %0d expected 4", digit); end
    send_byte(8'h74);
    checks++; if (digit !== 4'd6) begin errors++; $display("FAIL typ_refresh_right: got %0d expected 6", digit); end
    send_byte(8'hF0);
    send_byte(8'h6B);
    checks++; if (digit !== 4'd6) begin errors++; $display("FAIL typ_rel_left: got %0d expected 6", digit); end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h74);
    checks++; if (digit !== 4'd6) begin errors++; $display("FAIL ext_press: got %0d expected 6", digit); end
    checks++; if (jumpIsPressed !== 1'b0) begin errors++; $display("FAIL ext_press_jip: got %b expected 0", jumpIsPressed); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL ext_release: got %0d expected 0", digit); end
    checks++; if (jumpIsPressed !== 1'b0) begin errors++; $display("FAIL ext_release_jip: got %b expected 0", jumpIsPressed); end
  endtask

  task automatic test_unmapped();
    do_reset();
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h6B);
    checks++; if (digit !== 4'd4) begin errors++; $display("FAIL unmapped_clears_rel: got %0d expected 4", digit); end
  endtask

  task automatic test_bad_parity();
    do_reset();
    fe_base = fe_cnt;
    send_head(8'h29, 1'b1);
    ps2_bit(1'b1);
    checks++; if (fe_cnt - fe_base !== 1) begin errors++; $display("FAIL badpar_fe: got %0d expected 1", fe_cnt - fe_base); end
    checks++; if (jumpIsPressed !== 1'b0) begin errors++; $display("FAIL badpar_jip: got %b expected 0", jumpIsPressed); end
    fe_base = fe_cnt;
    send_byte(8'h29);
    checks++; if (jumpIsPressed !== 1'b1) begin errors++; $display("FAIL goodpar_jip: got %b expected 1", jumpIsPressed); end
    checks++; if (fe_cnt - fe_base !== 0) begin errors++; $display("FAIL goodpar_fe: got %0d expected 0", fe_cnt - fe_base); end
  endtask

  task automatic test_idle_noise();
    do_reset();
    fe_base = fe_cnt;
    ps2_bit(1'b1);
    checks++; if (fe_cnt - fe_base !== 1) begin errors++; $display("FAIL idle_noise_fe: got %0d expected 1", fe_cnt - fe_base); end
  endtask

  task automatic test_timeout();
    do_reset();
    fe_base = fe_cnt;
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    wait_clk(TO - 50);
    checks++; if (fe_cnt - fe_base !== 0) begin errors++; $display("FAIL timeout_early: got %0d expected 0", fe_cnt - fe_base); end
    wait_clk(100);
    checks++; if (fe_cnt - fe_base !== 1) begin errors++; $display("FAIL timeout_fe: got %0d expected 1", fe_cnt - fe_base); end
    send_byte(8'h6B);
    checks++; if (digit !== 4'd4) begin errors++; $display("FAIL timeout_recover: got %0d expected 4", digit); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_byte(8'h6B);
    send_byte(8'h29);
    checks++; if ({digit, digitIsPressed, jumpIsPressed} !== 6'b0100_1_1) begin errors++; $display("FAIL held_before_reset: got %b expected 010011", {digit, digitIsPressed, jumpIsPressed}); end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    PS2_DAT = 1'b0;
    wait_clk(5);
    PS2_CLK = 1'b0;
    wait_clk(4);
    #2 resetN = 1'b0;
    #1;
    checks++; if ({digit, digitIsPressed, jumpIsPressed, frameError} !== 7'd0) begin errors++; $display("FAIL async_reset_outputs: got %b expected 0000000", {digit, digitIsPressed, jumpIsPressed, frameError}); end
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    wait_clk(3);
    resetN = 1'b1;
    wait_clk(3);
    fe_base = fe_cnt;
    send_byte(8'hF0);
    send_byte(8'h29);
    checks++; if ({digit, digitIsPressed, jumpIsPressed} !== 6'd0) begin errors++; $display("FAIL after_reset_release: got %b expected 000000", {digit, digitIsPressed, jumpIsPressed}); end
    checks++; if (fe_cnt - fe_base !== 0) begin errors++; $display("FAIL after_reset_fe: got %0d expected 0", fe_cnt - fe_base); end
    send_byte(8'h74);
    checks++; if (digit !== 4'd6) begin errors++; $display("FAIL after_reset_decode: got %0d expected 6", digit); end
  endtask

  initial begin
    resetN  = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    test_reset();
    test_left_latency();
    test_left_right();
    test_typematic();
    test_extended();
    test_unmapped();
    test_bad_parity();
    test_idle_noise();
    test_timeout();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
